// File: rtl/instr_fetch.sv
// instr_fetch: assembles 1-3 byte instructions from byte-wide program memory for the cpu.
// Define INSTR_FETCH_STATS_EN to add the o_instr_count accepted-instruction counter.
module instr_fetch #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_wait,
  input  logic              i_pc_load,
  input  logic [ADDR_W-1:0] i_pc_value,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic [7:0]        i_mem_data,
  input  logic              i_mem_valid,
  output logic              o_instr_ready,
  output logic [7:0]        o_opcode,
  output logic [7:0]        o_data1,
  output logic [7:0]        o_data2,
  output logic [ADDR_W-1:0] o_instr_pc
`ifdef INSTR_FETCH_STATS_EN
  ,output logic [15:0]      o_instr_count
`endif
);
  typedef enum logic [1:0] {FETCH_OP, FETCH_D1, FETCH_D2, PRESENT} state_t;
  state_t state;
  logic [ADDR_W-1:0] ptr;
  assign o_mem_addr = ptr;
  assign o_mem_rd = state != PRESENT;
  assign o_instr_ready = state == PRESENT;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= FETCH_OP;
      ptr <= RESET_PC;
      o_opcode <= '0;
      o_data1 <= '0;
      o_data2 <= '0;
      o_instr_pc <= RESET_PC;
    end else if (i_pc_load) begin
      state <= FETCH_OP;
      ptr <= i_pc_value;
    end else begin
      case (state)
        FETCH_OP: if (i_mem_valid) begin
          o_opcode <= i_mem_data;
          o_instr_pc <= ptr;
          o_data1 <= '0;
          o_data2 <= '0;
          ptr <= ptr + 1'b1;
          state <= i_mem_data[7:6] == 2'b00 ? PRESENT : FETCH_D1;
        end
        FETCH_D1: if (i_mem_valid) begin
          o_data1 <= i_mem_data;
          ptr <= ptr + 1'b1;
          state <= o_opcode[7:6] == 2'b01 ? PRESENT : FETCH_D2;
        end
        FETCH_D2: if (i_mem_valid) begin
          o_data2 <= i_mem_data;
          ptr <= ptr + 1'b1;
          state <= PRESENT;
        end
        default: if (!i_cpu_wait) state <= FETCH_OP;
      endcase
    end
  end
`ifdef INSTR_FETCH_STATS_EN
  // acceptance is counted even when a redirect overrides the state change
  always_ff @(posedge i_clk) begin
    if (i_rst) o_instr_count <= '0;
    else if (o_instr_ready && !i_cpu_wait) o_instr_count <= o_instr_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized checks of instr_fetch against a byte-stream program model.
module tb_instr_fetch;
  logic clk, rst, cpu_wait, pc_load;
  logic [15:0] pc_value, mem_addr, instr_pc;
  logic mem_rd, mem_valid, instr_ready;
  logic [7:0] mem_data, opcode, data1, data2;
`ifdef INSTR_FETCH_STATS_EN
  logic [15:0] instr_count;
`endif
  int compared = 0;
  int mismatched = 0;
  logic [7:0] mem [65536];
  int mem_lat = 1;
  int lat_cnt = 0;
  bit spurious_en = 0;
  logic [15:0] last_addr = 16'h0;

  instr_fetch dut (
    .i_clk(clk), .i_rst(rst), .i_cpu_wait(cpu_wait), .i_pc_load(pc_load),
    .i_pc_value(pc_value), .o_mem_addr(mem_addr), .o_mem_rd(mem_rd),
    .i_mem_data(mem_data), .i_mem_valid(mem_valid), .o_instr_ready(instr_ready),
    .o_opcode(opcode), .o_data1(data1), .o_data2(data2), .o_instr_pc(instr_pc)
`ifdef INSTR_FETCH_STATS_EN
    , .o_instr_count(instr_count)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // program memory: answers mem_lat cycles after an address is first requested
  always @(posedge clk) begin
    #2;
    if (!mem_rd || mem_addr != last_addr) lat_cnt = 0;
    last_addr = mem_addr;
    if (mem_rd) begin
      lat_cnt++;
      mem_valid = lat_cnt >= mem_lat;
      mem_data = mem_valid ? mem[mem_addr] : 8'($urandom);
      if (mem_valid) lat_cnt = 0;
    end else begin
      mem_valid = spurious_en && $urandom_range(1) == 1;
      mem_data = 8'($urandom);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] a);
    pc_load = 1;
    pc_value = a;
    tick;
    pc_load = 0;
  endtask

  task automatic wait_ready(input int lim, output int n);
    n = 0;
    while (!instr_ready && n < lim) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    mem[0] = 8'h05;
    mem_lat = 1;
    cpu_wait = 0;
    rst = 1;
    tick;
    rst = 0;
    compared++;
    if (instr_ready !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin
      mismatched++;
      $display("FAIL reset_ctrl: ready=%b rd=%b addr=%h want 0 1 0000", instr_ready, mem_rd, mem_addr);
    end
    compared++;
    if (opcode !== 8'h00 || data1 !== 8'h00 || data2 !== 8'h00 || instr_pc !== 16'h0000) begin
      mismatched++;
      $display("FAIL reset_fields: op=%h d1=%h d2=%h pc=%h want 00 00 00 0000", opcode, data1, data2, instr_pc);
    end
    tick;
    compared++;
    if (instr_ready !== 1'b1 || opcode !== 8'h05 || data1 !== 8'h00 || data2 !== 8'h00 || instr_pc !== 16'h0000) begin
      mismatched++;
      $display("FAIL reset_first: ready=%b op=%h d1=%h d2=%h pc=%h want 1 05 00 00 0000", instr_ready, opcode, data1, data2, instr_pc);
    end
    tick;
    compared++;
    if (instr_ready !== 1'b0 || mem_addr !== 16'h0001) begin
      mismatched++;
      $display("FAIL reset_next: ready=%b addr=%h want 0 0001", instr_ready, mem_addr);
    end
  endtask

  task automatic test_three_byte;
    int n;
    mem[16'h0010] = 8'h80;
    mem[16'h0011] = 8'hAA;
    mem[16'h0012] = 8'h55;
    mem_lat = 1;
    cpu_wait = 1;
    do_load(16'h0010);
    wait_ready(20, n);
    compared++;
    if (instr_ready !== 1'b1 || n + 1 != 3 * 1 + 1) begin
      mismatched++;
      $display("FAIL three_latency: ready=%b cycles=%0d want 1 %0d", instr_ready, n + 1, 3 * 1 + 1);
    end
    compared++;
    if (opcode !== 8'h80 || data1 !== 8'hAA || data2 !== 8'h55 || instr_pc !== 16'h0010) begin
      mismatched++;
      $display("FAIL three_fields: op=%h d1=%h d2=%h pc=%h want 80 AA 55 0010", opcode, data1, data2, instr_pc);
    end
    cpu_wait = 0;
    tick;
    cpu_wait = 1;
    compared++;
    if (instr_ready !== 1'b0 || mem_addr !== 16'h0013) begin
      mismatched++;
      $display("FAIL three_next: ready=%b addr=%h want 0 0013", instr_ready, mem_addr);
    end
  endtask

  task automatic test_wait;
    int n;
    mem[16'h0030] = 8'h4F;
    mem[16'h0031] = 8'h9C;
    cpu_wait = 1;
    do_load(16'h0030);
    wait_ready(20, n);
    spurious_en = 1;
    for (int i = 0; i < 5; i++) begin
      tick;
      compared++;
      if (instr_ready !== 1'b1 || mem_rd !== 1'b0 || opcode !== 8'h4F || data1 !== 8'h9C || data2 !== 8'h00 || instr_pc !== 16'h0030) begin
        mismatched++;
        $display("FAIL wait_hold%0d: ready=%b rd=%b op=%h d1=%h d2=%h pc=%h want 1 0 4F 9C 00 0030", i, instr_ready, mem_rd, opcode, data1, data2, instr_pc);
      end
    end
    spurious_en = 0;
    cpu_wait = 0;
    tick;
    cpu_wait = 1;
    compared++;
    if (instr_ready !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0032) begin
      mismatched++;
      $display("FAIL wait_release: ready=%b rd=%b addr=%h want 0 1 0032", instr_ready, mem_rd, mem_addr);
    end
  endtask

  task automatic test_redirect;
    int n;
    mem[16'h0100] = 8'h40;
    mem[16'h0101] = 8'h77;
    mem[16'h0200] = 8'h01;
    cpu_wait = 1;
    do_load(16'h0100);
    tick;
    compared++;
    if (mem_addr !== 16'h0101 || mem_rd !== 1'b1 || opcode !== 8'h40) begin
      mismatched++;
      $display("FAIL redir_d1: addr=%h rd=%b op=%h want 0101 1 40", mem_addr, mem_rd, opcode);
    end
    pc_load = 1;
    pc_value = 16'h0200;
    tick;
    pc_load = 0;
    compared++;
    if (mem_addr !== 16'h0200 || instr_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL redir_addr: addr=%h ready=%b want 0200 0", mem_addr, instr_ready);
    end
    wait_ready(20, n);
    compared++;
    if (instr_ready !== 1'b1 || instr_pc !== 16'h0200 || opcode !== 8'h01 || data1 !== 8'h00) begin
      mismatched++;
      $display("FAIL redir_instr: ready=%b pc=%h op=%h d1=%h want 1 0200 01 00", instr_ready, instr_pc, opcode, data1);
    end
    cpu_wait = 0;
    tick;
    cpu_wait = 1;
  endtask

  task automatic test_wrap;
    int n;
    logic [15:0] pa;
    logic [15:0] reads[$];
    mem[16'hFFFE] = 8'hC3;
    mem[16'hFFFF] = 8'h11;
    mem[16'h0000] = 8'h22;
    mem_lat = 3;
    cpu_wait = 1;
    do_load(16'hFFFE);
    n = 0;
    while (!instr_ready && n < 40) begin
      pa = mem_addr;
      tick;
      n++;
      if (mem_valid) reads.push_back(pa);
      else begin
        compared++;
        if (mem_addr !== pa) begin
          mismatched++;
          $display("FAIL wrap_stable: addr=%h want %h", mem_addr, pa);
        end
      end
    end
    compared++;
    if (instr_ready !== 1'b1 || n + 1 != 3 * 3 + 1) begin
      mismatched++;
      $display("FAIL wrap_latency: ready=%b cycles=%0d want 1 %0d", instr_ready, n + 1, 3 * 3 + 1);
    end
    compared++;
    if (reads.size() != 3 || reads[0] !== 16'hFFFE || reads[1] !== 16'hFFFF || reads[2] !== 16'h0000) begin
      mismatched++;
      $display("FAIL wrap_reads: got %0d reads %p want FFFE FFFF 0000", reads.size(), reads);
    end
    compared++;
    if (opcode !== 8'hC3 || data1 !== 8'h11 || data2 !== 8'h22 || instr_pc !== 16'hFFFE) begin
      mismatched++;
      $display("FAIL wrap_fields: op=%h d1=%h d2=%h pc=%h want C3 11 22 FFFE", opcode, data1, data2, instr_pc);
    end
    cpu_wait = 0;
    tick;
    cpu_wait = 1;
    compared++;
    if (mem_addr !== 16'h0001 || instr_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL wrap_next: addr=%h ready=%b want 0001 0", mem_addr, instr_ready);
    end
    mem_lat = 1;
  endtask

  task automatic test_stats;
`ifdef INSTR_FETCH_STATS_EN
    int n;
    cpu_wait = 1;
    rst = 1;
    tick;
    rst = 0;
    for (int k = 1; k <= 3; k++) begin
      wait_ready(20, n);
      cpu_wait = 0;
      if (k == 3) begin
        pc_load = 1;
        pc_value = 16'h0040;
      end
      tick;
      cpu_wait = 1;
      pc_load = 0;
      compared++;
      if (instr_count !== 16'(k)) begin
        mismatched++;
        $display("FAIL stats_count%0d: got %0d want %0d", k, instr_count, k);
      end
    end
    rst = 1;
    tick;
    rst = 0;
    compared++;
    if (instr_count !== 16'd0) begin
      mismatched++;
      $display("FAIL stats_reset: got %0d want 0", instr_count);
    end
`endif
  endtask

  // reference: the fetch engine walks the program as a byte stream; each accepted
  // instruction is the opcode at the model pointer plus its 0-2 operand bytes
  task automatic test_random;
    logic [15:0] eptr, pa, lv;
    logic [7:0] op, e1, e2;
    bit pr, ld;
    int len;
    int accepted = 0;
    cpu_wait = 1;
    do_load(16'h1000);
    eptr = 16'h1000;
    spurious_en = 1;
    for (int r = 0; r < 4; r++) begin
      mem_lat = 1 + r % 3;
      for (int c = 0; c < 600; c++) begin
        cpu_wait = $urandom_range(3) == 0;
        ld = $urandom_range(40) == 0;
        lv = 16'($urandom);
        pc_load = ld;
        pc_value = lv;
        pa = mem_addr;
        pr = mem_rd;
        if (instr_ready && !cpu_wait) begin
          op = mem[eptr];
          len = op[7:6] == 2'b00 ? 1 : op[7:6] == 2'b01 ? 2 : 3;
          e1 = len > 1 ? mem[eptr + 16'd1] : 8'h00;
          e2 = len > 2 ? mem[eptr + 16'd2] : 8'h00;
          compared++;
          if (opcode !== op || data1 !== e1 || data2 !== e2 || instr_pc !== eptr) begin
            mismatched++;
            $display("FAIL rand_instr: op=%h d1=%h d2=%h pc=%h want %h %h %h %h", opcode, data1, data2, instr_pc, op, e1, e2, eptr);
          end
          eptr = eptr + 16'(len);
          accepted++;
        end
        if (ld) eptr = lv;
        tick;
        compared++;
        if (mem_rd !== !instr_ready) begin
          mismatched++;
          $display("FAIL rand_rd: rd=%b ready=%b want opposite", mem_rd, instr_ready);
        end
        if (ld) begin
          compared++;
          if (mem_addr !== lv || instr_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL rand_load: addr=%h ready=%b want %h 0", mem_addr, instr_ready, lv);
          end
        end else if (pr && !mem_valid) begin
          compared++;
          if (mem_addr !== pa) begin
            mismatched++;
            $display("FAIL rand_stable: addr=%h want %h", mem_addr, pa);
          end
        end
      end
    end
    pc_load = 0;
    spurious_en = 0;
    mem_lat = 1;
    compared++;
    if (accepted < 50) begin
      mismatched++;
      $display("FAIL rand_progress: accepted %0d want at least 50", accepted);
    end
  endtask

  initial begin
    rst = 1;
    cpu_wait = 1;
    pc_load = 0;
    pc_value = 16'h0;
    mem_valid = 0;
    mem_data = 8'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) tick;
    test_reset;
    test_three_byte;
    test_wait;
    test_redirect;
    test_wrap;
    test_stats;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
